// File: rtl/usb_pkg.sv
// Shared types and constants for the USB transmit path.
package usb_pkg;

  // Packet request presented to the TX encoder.
  typedef enum logic [2:0] {
    TX_NONE  = 3'd0,
    TX_DATA  = 3'd1,
    TX_ACK   = 3'd2,
    TX_NAK   = 3'd3,
    TX_STALL = 3'd4
  } tx_pkt_t;

  // Command codes written by the register block.
  localparam logic [7:0] CMD_DATA  = 8'd1;
  localparam logic [7:0] CMD_ACK   = 8'd2;
  localparam logic [7:0] CMD_NAK   = 8'd3;
  localparam logic [7:0] CMD_STALL = 8'd4;

  // Error codes reported alongside the err pulse.
  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TX      = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_REJECT  = 2'd3
  } tx_err_t;

  // Map a command code to its packet; unknown codes map to TX_NONE.
  function automatic tx_pkt_t cmd_to_pkt(input logic [7:0] code);
    case (code)
      CMD_DATA:  return TX_DATA;
      CMD_ACK:   return TX_ACK;
      CMD_NAK:   return TX_NAK;
      CMD_STALL: return TX_STALL;
      default:   return TX_NONE;
    endcase
  endfunction

endpackage

// File: rtl/usb_tx_scheduler_timeout.sv
// Saturating start-timeout counter. expired flags the enabled cycle whose
// increment brings the count to TERMINAL.
module tx_timeout_counter #(
  parameter int TERMINAL = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TERMINAL + 1);

  logic [CW-1:0] count_q;

  // Count enabled cycles, holding at TERMINAL rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count_q <= '0;
    else if (clear)
      count_q <= '0;
    else if (enable && (count_q != CW'(TERMINAL)))
      count_q <= count_q + 1'b1;
  end

  assign expired = enable && (count_q == CW'(TERMINAL - 1));

endmodule

// File: rtl/usb_tx_scheduler.sv
// Sequences commands from the register block to the TX encoder, tracks each
// transfer to completion and defers buffer flushes until the bus is quiet.
module usb_tx_scheduler
  import usb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int OCC_W          = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [7:0]       cmd_code,
  input  logic             flush_req,
  input  logic [OCC_W-1:0] buffer_occupancy,
  input  logic             tx_transfer_active,
  input  logic             tx_error,
  output logic             cmd_ready,
  output logic [2:0]       tx_packet,
  output logic             clear,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ACTIVE, S_FLUSH} state_t;

  state_t  state_q, state_d;
  tx_pkt_t pkt_q, pkt_d;
  logic    pend_q, pend_d;
  logic    sticky_q, sticky_d;
  tx_pkt_t tx_packet_q, tx_packet_d;
  logic    clear_q, clear_d;
  logic    busy_q, busy_d;
  logic    done_q, done_d;
  logic    err_q, err_d;
  tx_err_t err_code_q, err_code_d;
  logic    cmd_ready_q, cmd_ready_d;
  logic    expired;
  logic    cmd_ok;

  tx_timeout_counter #(.TERMINAL(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q != S_ISSUE),
    .enable  (state_q == S_ISSUE),
    .expired (expired)
  );

  // A command is acceptable if its code is known and DATA has bytes to send.
  assign cmd_ok = (cmd_to_pkt(cmd_code) != TX_NONE) &&
                  !((cmd_code == CMD_DATA) && (buffer_occupancy == '0));

  // Next-state and registered-output decode.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    state_d    = state_q;
    pkt_d      = pkt_q;
    pend_d     = pend_q | flush_req;
    sticky_d   = sticky_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    case (state_q)
      S_IDLE: begin
        if (pend_q || flush_req) begin
          state_d = S_FLUSH;
          pend_d  = 1'b0;
          if (cmd_valid) begin
            err_d      = 1'b1;
            err_code_d = ERR_REJECT;
          end
        end else if (cmd_valid) begin
          if (cmd_ok) begin
            state_d    = S_ISSUE;
            pkt_d      = cmd_to_pkt(cmd_code);
            err_code_d = ERR_NONE;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_REJECT;
          end
        end
      end
      S_ISSUE: begin
        if (tx_transfer_active) begin
          state_d = S_ACTIVE;
        end else if (expired) begin
          state_d    = S_IDLE;
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end
      end
      S_ACTIVE: begin
        if (!tx_transfer_active) begin
          state_d  = S_IDLE;
          sticky_d = 1'b0;
          if (sticky_q) begin
            err_d      = 1'b1;
            err_code_d = ERR_TX;
          end else begin
            done_d = 1'b1;
          end
        end else if (tx_error) begin
          sticky_d = 1'b1;
        end
      end
      S_FLUSH: begin
        state_d = S_IDLE;
        pend_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    tx_packet_d = (state_d == S_ISSUE) ? pkt_d : TX_NONE;
    clear_d     = (state_d == S_FLUSH);
    busy_d      = (state_d != S_IDLE);
    cmd_ready_d = (state_d == S_IDLE) && !pend_d;
  end

  // State and output registers; reset aborts any transfer silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pkt_q       <= TX_NONE;
      pend_q      <= 1'b0;
      sticky_q    <= 1'b0;
      tx_packet_q <= TX_NONE;
      clear_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      cmd_ready_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q     <= state_d;
      pkt_q       <= pkt_d;
      pend_q      <= pend_d;
      sticky_q    <= sticky_d;
      tx_packet_q <= tx_packet_d;
      clear_q     <= clear_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign tx_packet = tx_packet_q;
  assign clear     = clear_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Scoreboard bench for usb_tx_scheduler: drivers push expected events
// (packet runs, done, err, clear) with their cycle stamps; a monitor pops and
// compares them as the DUT produces them.
module tb_usb_tx_scheduler;

  localparam int T = 8;

  localparam logic [7:0] EV_PKT  = 8'd1;
  localparam logic [7:0] EV_ERR  = 8'd2;
  localparam logic [7:0] EV_DONE = 8'd3;
  localparam logic [7:0] EV_CLR  = 8'd4;

  typedef struct packed {
    logic [7:0]  kind;
    logic [7:0]  val;
    logic [15:0] len;
    logic [31:0] cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_code = 8'd0;
  logic       flush_req = 1'b0;
  logic [6:0] buffer_occupancy = 7'd0;
  logic       tx_transfer_active = 1'b0;
  logic       tx_error = 1'b0;
  logic       cmd_ready;
  logic [2:0] tx_packet;
  logic       clear;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;

  usb_tx_scheduler #(.TIMEOUT_CYCLES(T), .OCC_W(7)) dut (
    .clk                (clk),
    .rst                (rst),
    .cmd_valid          (cmd_valid),
    .cmd_code           (cmd_code),
    .flush_req          (flush_req),
    .buffer_occupancy   (buffer_occupancy),
    .tx_transfer_active (tx_transfer_active),
    .tx_error           (tx_error),
    .cmd_ready          (cmd_ready),
    .tx_packet          (tx_packet),
    .clear              (clear),
    .busy               (busy),
    .done               (done),
    .err                (err),
    .err_code           (err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic ev_t mk(input logic [7:0] k, input int v, input int l, input int c);
    ev_t e;
    e.kind = k; e.val = 8'(v); e.len = 16'(l); e.cyc = 32'(c);
    return e;
  endfunction

  task automatic observe(input string name, input ev_t o);
    if (exp_q.size() == 0) check({"unexpected ", name}, o, 64'd0);
    else check(name, o, exp_q.pop_front());
  endtask

  // Monitor: samples on the falling edge, reports packet runs when they end.
  int         run_len = 0;
  int         run_start = 0;
  logic [2:0] run_val = 3'd0;
  always @(negedge clk) begin
    if (rst) begin
      run_len = 0;
    end else begin
      if (tx_packet != 3'd0) begin
        if (run_len == 0) begin
          run_start = cyc;
          run_val   = tx_packet;
        end
        run_len++;
      end else if (run_len > 0) begin
        observe("pkt", mk(EV_PKT, run_val, run_len, run_start));
        run_len = 0;
      end
      if (err)   observe("err",   mk(EV_ERR,  err_code, 0, cyc));
      if (done)  observe("done",  mk(EV_DONE, err_code, 0, cyc));
      if (clear) observe("clear", mk(EV_CLR,  0, 0, cyc));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_cycle(input int c);
    while (cyc < c) tick();
  endtask

  task automatic wait_ready();
    int b = 0;
    while (!cmd_ready && b < 100) begin
      tick();
      b++;
    end
    if (!cmd_ready) check("cmd_ready wait", cmd_ready, 1);
  endtask

  // Ready/busy checks shared by all transaction drivers.
  task automatic ready_checks(input int c, input int n, input int r);
    if (c == r - 1 && c > n) check("cmd_ready low before return", cmd_ready, 0);
    if (c == r) begin
      check("cmd_ready on return", cmd_ready, 1);
      check("busy on return", busy, 0);
    end
  endtask

  // One command transaction. d: ISSUE cycles before active rises; l: active
  // length; e_off: error offset into the transfer (0 = none).
  task automatic run_cmd(input int code, input int occ, input int d, input int l,
                         input int e_off, input int n_flush, input bit spur,
                         input bit tmo);
    int  n, r, end_c, t;
    bit  acc;
    wait_ready();
    n   = cyc;
    acc = (code >= 1 && code <= 4) && !(code == 1 && occ == 0);
    if (!acc) begin
      exp_q.push_back(mk(EV_ERR, 3, 0, n + 1));
      r = n + 1; end_c = n;
    end else if (tmo) begin
      exp_q.push_back(mk(EV_PKT, code, T, n + 1));
      exp_q.push_back(mk(EV_ERR, 2, 0, n + T + 1));
      r = n + T + 1; end_c = n + T;
    end else begin
      exp_q.push_back(mk(EV_PKT, code, d + 1, n + 1));
      end_c = n + 1 + d + l;
      if (e_off != 0) exp_q.push_back(mk(EV_ERR, 1, 0, end_c + 1));
      else            exp_q.push_back(mk(EV_DONE, 0, 0, end_c + 1));
      if (n_flush > 0) begin
        exp_q.push_back(mk(EV_CLR, 0, 0, end_c + 2));
        r = end_c + 3;
      end else begin
        r = end_c + 1;
      end
    end
    for (int c = n; c <= r; c++) begin
      goto_cycle(c);
      t = c - n;
      ready_checks(c, n, r);
      if (acc && t == 1) check("busy after accept", busy, 1);
      if (!acc && t == 1) check("busy after reject", busy, 0);
      cmd_code           = 8'(code);
      buffer_occupancy   = 7'(occ);
      cmd_valid          = (t == 0) || (spur && acc && !tmo && t == d + 2);
      tx_transfer_active = acc && !tmo && t >= d + 1 && t <= d + l;
      tx_error           = acc && !tmo && e_off != 0 && t == d + 1 + e_off;
      flush_req          = acc && !tmo && ((n_flush >= 1 && t == d + 2) ||
                                           (n_flush >= 2 && t == d + l));
    end
    cmd_valid = 1'b0; tx_transfer_active = 1'b0; tx_error = 1'b0; flush_req = 1'b0;
  endtask

  // Flush from IDLE, optionally colliding with a command strobe.
  task automatic run_flush(input bit with_cmd);
    int n;
    wait_ready();
    n = cyc;
    if (with_cmd) exp_q.push_back(mk(EV_ERR, 3, 0, n + 1));
    exp_q.push_back(mk(EV_CLR, 0, 0, n + 1));
    for (int c = n; c <= n + 2; c++) begin
      goto_cycle(c);
      ready_checks(c, n, n + 2);
      flush_req        = (c == n);
      cmd_valid        = with_cmd && (c == n);
      cmd_code         = 8'd2;
      buffer_occupancy = 7'd1;
    end
  endtask

  // Reset in the middle of a transfer with a flush pending: nothing may follow.
  task automatic run_reset_active();
    int n;
    wait_ready();
    n = cyc;
    exp_q.push_back(mk(EV_PKT, 2, 2, n + 1));
    for (int c = n; c <= n + 4; c++) begin
      goto_cycle(c);
      cmd_valid          = (c == n);
      cmd_code           = 8'd2;
      tx_transfer_active = (c >= n + 2);
      flush_req          = (c == n + 3);
    end
    #2 rst = 1'b1;
    #1;
    check("rst tx_packet", tx_packet, 0);
    check("rst busy", busy, 0);
    check("rst outputs", {done, err, clear, cmd_ready}, 4'b0000);
    check("rst err_code", err_code, 0);
    tick();
    rst = 1'b0;
    tx_transfer_active = 1'b0;
    repeat (10) tick();
    check("no events after reset", exp_q.size(), 0);
  endtask

  initial begin
    int kind, code, d, l;
    repeat (3) tick();
    check("reset tx_packet", tx_packet, 0);
    check("reset flags", {busy, done, err, clear}, 4'b0000);
    check("reset err_code", err_code, 0);
    rst = 1'b0;

    run_cmd(2, 5, 3, 5, 0, 0, 0, 0);   // ACK, 4 cycles of TX_ACK
    run_cmd(1, 0, 0, 2, 0, 0, 0, 0);   // DATA, empty buffer -> reject
    run_cmd(1, 12, 1, 3, 0, 0, 0, 0);  // DATA with bytes
    run_cmd(3, 4, 0, 2, 0, 0, 0, 1);   // NAK start timeout
    run_cmd(4, 0, 2, 6, 2, 2, 0, 0);   // STALL, tx_error, two flushes
    run_cmd(9, 3, 0, 2, 0, 0, 0, 0);   // unknown code
    run_cmd(0, 3, 0, 2, 0, 0, 0, 0);   // unknown code
    run_cmd(2, 1, 0, 2, 0, 0, 1, 0);   // zero-delay start, ignored strobe
    run_flush(0);
    run_flush(1);
    run_reset_active();

    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 9));
      if (kind == 0) run_flush(0);
      else if (kind == 1) run_flush(1);
      else if (kind == 2) begin
        code = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(5, 255));
        run_cmd(code, int'($urandom_range(0, 20)), 0, 2, 0, 0, 0, 0);
      end else begin
        code = int'($urandom_range(1, 4));
        d    = int'($urandom_range(0, T - 1));
        l    = int'($urandom_range(2, 6));
        run_cmd(code, int'($urandom_range(0, 20)), d, l,
                ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, l - 1)) : 0,
                int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0));
      end
    end

    repeat (5) tick();
    check("scoreboard drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/usb_tx_scheduler.md
# usb_tx_scheduler

Sequences transmit requests from the AHB-lite slave register block to the USB TX encoder. Accepts one command at a time (DATA, ACK, NAK, STALL) and checks buffer occupancy before a DATA request. Drives `tx_packet` until the encoder starts, then tracks the transfer to completion and reports done or error. It also orders buffer-flush requests so a flush never hits the buffer mid-transfer.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: max cycles in ISSUE waiting for `tx_transfer_active`; must be ≥1.
- `OCC_W`, 7: width of `buffer_occupancy`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: one-cycle command strobe from the register block.
- `cmd_code` in 8: 1=DATA, 2=ACK, 3=NAK, 4=STALL; any other value is invalid.
- `flush_req` in 1: one-cycle flush request.
- `buffer_occupancy` in OCC_W: current data-buffer byte count.
- `tx_transfer_active` in 1: TX encoder is busy.
- `tx_error` in 1: TX encoder error, valid while active.
- `cmd_ready` out 1: high only in IDLE with no flush pending.
- `tx_packet` out 3: packet request; TX_NONE when not in ISSUE.
- `clear` out 1: one-cycle buffer flush strobe.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse on successful completion.
- `err` out 1: one-cycle error pulse.
- `err_code` out 2: 0=none, 1=tx_error, 2=start timeout, 3=rejected.

## Operation
- States: IDLE, ISSUE, ACTIVE, FLUSH. All outputs are registered.
- **Reset:** state IDLE; `tx_packet`=TX_NONE; `clear`, `done`, `err`, `busy` are 0; `err_code` is 0. Timeout counter, flush-pending flag and sticky error flag are all 0. Reset mid-transfer aborts immediately with no `done` or `err`.
- **IDLE, priority order:**
  1. Flush pending or `flush_req` → FLUSH.
  2. `cmd_valid` with a valid code → ISSUE; latch the code; clear `err_code`.
  3. Otherwise stay in IDLE.
- **IDLE, rejection (err pulse, code 3, stay IDLE):**
  - `cmd_valid` with an invalid code.
  - DATA with `buffer_occupancy`==0.
  - `cmd_valid` in the same cycle as `flush_req`; flush wins.
- **ISSUE:**
  - `tx_packet` = latched packet; the counter increments every cycle.
  - `tx_transfer_active`=1 → ACTIVE; counter cleared.
  - Counter reaches `TIMEOUT_CYCLES` first → IDLE with err pulse, code 2.
- **ACTIVE:**
  - `tx_packet`=TX_NONE.
  - Any cycle with `tx_error`=1 sets the sticky error flag.
  - On `tx_transfer_active`=0 → IDLE, pulsing `done` (flag clear) or `err` with code 1 (flag set). The flag then clears.
- **FLUSH:** `clear`=1 for exactly one cycle, then IDLE; the pending flag clears.
- **`flush_req` outside IDLE:** sets the pending flag, serviced on return to IDLE. Multiple requests collapse into one.
- **`cmd_valid` outside IDLE:** ignored, no error; the source must honour `cmd_ready`.
- **`err_code`:** holds its last value until the next accepted command or reset.

## Timing
- Command latency: `cmd_valid` at cycle N (IDLE) → `tx_packet` valid from N+1, `busy`=1 from N+1.
- Start: `tx_transfer_active` first sampled high at cycle M → `tx_packet`=TX_NONE at M+1.
- Completion: `tx_transfer_active` sampled low at cycle K → `done`/`err` high at K+1 only. State is IDLE at K+1; `cmd_ready` is high at K+1 unless a flush is pending.
- Timeout: if active never rises, `err` fires exactly `TIMEOUT_CYCLES`+1 cycles after `cmd_valid`.
- Flush: `flush_req` at N in IDLE → `clear` at N+1, `cmd_ready` back high at N+2.
- Rejection: `err` at N+1, with no state change.
- Counter width: `$clog2(TIMEOUT_CYCLES+1)`. It saturates and never wraps.

## Structure
- Shared package `usb_pkg`:
  - `tx_pkt_t` (3-bit: TX_NONE=0, TX_DATA=1, TX_ACK=2, TX_NAK=3, TX_STALL=4).
  - Command code constants.
  - `tx_err_t` (2-bit error codes).
- FSM state enum stays local to the module.
- One sub-module, `tx_timeout_counter`: clear, enable, parameterised terminal count, `expired` flag.

## Test plan
- ACK command (code 2); active rises 3 cycles later, is held for 5 cycles, no error → `tx_packet`=2 for 4 cycles; `done` pulses once; `err_code`=0.
- DATA with occupancy 0 → `err` at N+1, `err_code`=3, state stays IDLE, `tx_packet` never leaves 0. Repeat with occupancy 12 → `tx_packet`=1.
- NAK with `TIMEOUT_CYCLES`=8 and active held low → `err` at N+9, `err_code`=2, `busy`=0 after.
- STALL; `tx_error` pulses mid-transfer; `flush_req` pulses twice during ACTIVE. Required response:
  - `err` with code 1 at active fall +1.
  - A single `clear` pulse one cycle later.
  - `cmd_ready` high one cycle after `clear`.
- `cmd_valid`+`flush_req` in the same IDLE cycle → `clear` at N+1 and `err_code`=3. Then assert `rst` during ACTIVE → all outputs 0 immediately; no `done` or `err` afterwards.
